alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: rq_valid[1:0]  in  2  request valid, one bit per requester (0, 1).
REQ-004 SHALL have ports: rq_ready[1:0]  out  2  request accepted (grant) this cycle.
REQ-005 SHALL have ports: rq_op[i]  in  aluop_t  op for requester i; rq_a[i], rq_b[i]  in  word_t  operands.
REQ-006 SHALL have ports: rs_valid[1:0]  out  2  result held for requester i.
REQ-007 SHALL have ports: rs_ready[1:0]  in  2  requester i consumes its result.
REQ-008 SHALL have ports: rs_out[i]  out  word_t  result; rs_flags[i]  out  3  {overflow, negative, zero}.
REQ-009 SHALL have ports: alu_op  out  aluop_t; alu_a, alu_b  out  word_t; all drive the shared combinational ALU.
REQ-010 SHALL have ports: alu_out  in  word_t; alu_zero, alu_neg, alu_ovf  in  1; all returned from the ALU.

Function
REQ-011 SHALL grant at most one requester per cycle; the grant is combinational from rq_valid, slot state and the arbitration pointer.
REQ-012 SHALL treat requester i as eligible when rq_valid[i] && (!rs_valid[i] || rs_ready[i]).
REQ-013 SHALL drive alu_op/alu_a/alu_b from the granted requester, and all zeros when nothing is granted.
REQ-014 SHALL capture alu_out and flags into slot i at the edge ending the grant cycle, and set rs_valid[i]=1 next cycle (latency 1).
REQ-015 SHALL hold rs_out/rs_flags/rs_valid stable until rs_ready[i] is sampled high; when the slot is consumed and nothing is refilled, rs_valid[i] clears the next cycle.
REQ-016 SHALL, on consume and regrant of the same slot in one cycle, keep rs_valid[i]=1 with the new data (back-to-back, 1 op/cycle).
REQ-017 SHALL keep a 2-state pointer last_grant (LG0, LG1); it moves to LGi only on a cycle that grants i, and otherwise holds.
REQ-018 SHALL resolve two eligible requesters in favour of the one not equal to last_grant (round-robin).
REQ-019 SHALL drop rq_valid with no effect if it falls before a grant; no request is queued internally.
REQ-020 SHALL pass ALU flags through unmodified, including the SLT/SLTU zero flag.

Reset
REQ-021 SHALL, while RST=1, force rs_valid=0, rs_out=0, rs_flags=0 and last_grant=LG1, so requester 0 wins the first tie.
REQ-022 SHALL drive rq_ready=0 during reset, so no grant is issued.
REQ-023 SHALL lose any op in flight at reset assertion; no result is reported after reset.

Configuration
REQ-024 SHALL support macro ALU_ARB_RR_EN; when it is defined, round-robin operates per REQ-017/018.
REQ-025 SHALL, without ALU_ARB_RR_EN, use fixed priority with requester 0 always winning ties; last_grant is not implemented.

Structure
REQ-026 SHALL place the arbiter state enum (LG0, LG1), a NUM_REQ=2 constant and a flag-bundle struct in cpu_types_pkg; word_t and aluop_t come from the same package.
REQ-027 SHALL implement the per-requester result slot as one sub-module, alu_rsp_slot, instantiated twice.

Verification
REQ-028 SHALL test a single request: rq_valid[0]=1, ADD 5+7 -> rq_ready[0]=1 same cycle; rs_valid[0]=1 next cycle with rs_out=12 and flags=000.
REQ-029 SHALL test a tie under RR: both valid continuously with rs_ready=11 -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-030 SHALL test backpressure: rs_ready[1]=0, slot 1 full, rq_valid[1]=1 -> rq_ready[1]=0; requester 0 is granted every cycle.
REQ-031 SHALL test overflow: SUB 0x80000000-1 on requester 1 -> rs_out=0x7FFFFFFF, flags=100.
REQ-032 SHALL test back-to-back: same-cycle consume and regrant of slot 0 -> rs_valid[0] stays 1 and data updates each cycle.
REQ-033 SHALL test mid-op reset: RST pulsed in the grant cycle -> rs_valid=00 after reset, and the first subsequent tie goes to requester 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcode, arbiter pointer state and the
// ALU flag bundle used by alu_arbiter and its result slots.
package cpu_types_pkg;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Round-robin pointer: which requester received the most recent grant.
  typedef enum logic {
    LG0 = 1'b0,
    LG1 = 1'b1
  } lg_state_t;

  // Packed as {overflow, negative, zero}.
  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-deep result holding register for a single requester. A load wins over
// a consume in the same cycle, which gives back-to-back operation.
module alu_rsp_slot
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic       consume,
  input  word_t      load_data,
  input  alu_flags_t load_flags,
  output logic       valid,
  output word_t      data,
  output alu_flags_t flags
);

  // Capture a new result, or release the slot once the requester takes it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the data registers are reset too, because the result outputs
      // must read as zero while reset is held, not merely be marked invalid.
      valid <= 1'b0;
      data  <= '0;
      flags <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        flags <= load_flags;
      end else if (consume) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin tie breaking; without it requester 0
// always wins a tie and no arbitration pointer is kept.
module alu_arbiter
  import cpu_types_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] rq_valid,
  output logic [NUM_REQ-1:0] rq_ready,
  input  aluop_t             rq_op    [NUM_REQ],
  input  word_t              rq_a     [NUM_REQ],
  input  word_t              rq_b     [NUM_REQ],
  output logic [NUM_REQ-1:0] rs_valid,
  input  logic [NUM_REQ-1:0] rs_ready,
  output word_t              rs_out   [NUM_REQ],
  output alu_flags_t         rs_flags [NUM_REQ],
  output aluop_t             alu_op,
  output word_t              alu_a,
  output word_t              alu_b,
  input  word_t              alu_out,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic               alu_ovf
);

  logic [NUM_REQ-1:0] eligible;
  alu_flags_t         alu_flags;

  // A requester may be granted only if its slot is empty or being drained now.
  assign eligible  = rq_valid & (~rs_valid | rs_ready);
  assign alu_flags = '{ovf: alu_ovf, neg: alu_neg, zero: alu_zero};

`ifdef ALU_ARB_RR_EN
  lg_state_t last_grant;

  // Round-robin pointer follows the requester granted this cycle; idle cycles hold it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant <= LG1;
    end else if (rq_ready[0]) begin
      last_grant <= LG0;
    end else if (rq_ready[1]) begin
      last_grant <= LG1;
    end
  end
`endif

  // Grant decision: at most one requester, nothing while reset is asserted.
  always_comb begin
    // NOTE: default assignment first, so no path through this block leaves
    // rq_ready unassigned and infers a latch.
    rq_ready = '0;
    if (!RST) begin
      if (eligible == 2'b11) begin
`ifdef ALU_ARB_RR_EN
        rq_ready = (last_grant == LG0) ? 2'b10 : 2'b01;
`else
        rq_ready = 2'b01;
`endif
      end else begin
        rq_ready = eligible;
      end
    end
  end

  // Route the granted requester's operation to the ALU; idle drives zeros.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq_ready[i]) begin
        alu_op = rq_op[i];
        alu_a  = rq_a[i];
        alu_b  = rq_b[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    alu_rsp_slot u_slot (
      .CLK        (CLK),
      .RST        (RST),
      .load       (rq_ready[g]),
      .consume    (rs_ready[g]),
      .load_data  (alu_out),
      .load_flags (alu_flags),
      .valid      (rs_valid[g]),
      .data       (rs_out[g]),
      .flags      (rs_flags[g])
    );
  end

endmodule
